// File: rtl/decode_pkg.sv
// Shared decode definitions: WISC opcodes, control-bundle layout, stage FSM states.
// Build option: DECODE_EXC_EN (makes SIIC/RTI legal; see opc_ctrl_rom).
package decode_pkg;

  localparam int CTRL_BITS = 27;

  localparam logic [4:0] OPC_HALT = 5'b00000;
  localparam logic [4:0] OPC_NOP  = 5'b00001;
  localparam logic [4:0] OPC_SIIC = 5'b00010;
  localparam logic [4:0] OPC_RTI  = 5'b00011;
  localparam logic [4:0] OPC_J    = 5'b00100;
  localparam logic [4:0] OPC_JR   = 5'b00101;
  localparam logic [4:0] OPC_JAL  = 5'b00110;
  localparam logic [4:0] OPC_JALR = 5'b00111;
  localparam logic [4:0] OPC_ST   = 5'b10000;
  localparam logic [4:0] OPC_LD   = 5'b10001;
  localparam logic [4:0] OPC_SLBI = 5'b10010;
  localparam logic [4:0] OPC_STU  = 5'b10011;
  localparam logic [4:0] OPC_LBI  = 5'b11000;
  localparam logic [4:0] OPC_BTR  = 5'b11001;

  // Destination register select
  localparam logic [1:0] DST_RD = 2'd0;  // instr[4:2]  (R-format)
  localparam logic [1:0] DST_RT = 2'd1;  // instr[7:5]  (I-format 1)
  localparam logic [1:0] DST_RS = 2'd2;  // instr[10:8] (I-format 2)
  localparam logic [1:0] DST_R7 = 2'd3;  // link register

  // Immediate select
  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_S5   = 3'd1;
  localparam logic [2:0] IMM_Z5   = 3'd2;
  localparam logic [2:0] IMM_S8   = 3'd3;
  localparam logic [2:0] IMM_Z8   = 3'd4;
  localparam logic [2:0] IMM_D11  = 3'd5;

  // Write-back source
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  // Bit offsets of the bundle fields (LSB first)
  localparam int F_ALU_OP   = 0;   // 5 bits
  localparam int F_REG_WRT  = 5;
  localparam int F_REG_DST  = 6;   // 2 bits
  localparam int F_ALU_SRC  = 8;
  localparam int F_IMM_SEL  = 9;   // 3 bits
  localparam int F_MEM_RD   = 12;
  localparam int F_MEM_WR   = 13;
  localparam int F_WB_SEL   = 14;  // 2 bits
  localparam int F_BRANCH   = 16;
  localparam int F_BR_COND  = 17;  // 2 bits: eqz/nez/ltz/gez
  localparam int F_JUMP     = 19;
  localparam int F_JUMP_REG = 20;
  localparam int F_LINK     = 21;
  localparam int F_HALT     = 22;
  localparam int F_EXC      = 23;
  localparam int F_RTI      = 24;
  localparam int F_FUNCT_EN = 25;
  localparam int F_RS_RD    = 26;

  // Same layout as the offsets above, MSB first
  typedef struct packed {
    logic       rs_rd;
    logic       funct_en;
    logic       rti;
    logic       exc;
    logic       halt;
    logic       link;
    logic       jump_reg;
    logic       jump;
    logic [1:0] br_cond;
    logic       branch;
    logic [1:0] wb_sel;
    logic       mem_wr;
    logic       mem_rd;
    logic [2:0] imm_sel;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic       reg_wrt;
    logic [4:0] alu_op;
  } ctrl_t;

  typedef enum logic [1:0] {ST_RUN, ST_HALT_PEND, ST_HALTED} state_t;

endpackage

// File: rtl/opc_ctrl_rom.sv
// Combinational opcode -> {legal, control bundle} table. Unused fields are always 0.
// Build option: DECODE_EXC_EN makes SIIC/RTI legal; otherwise they decode as illegal.
module opc_ctrl_rom
  import decode_pkg::*;
#(
  parameter int OPC_W  = 5,
  parameter int CTRL_W = 27
) (
  input  logic [OPC_W-1:0]  opc_i,
  output logic              legal_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  ctrl_t c;
  logic  legal;

  // Per-opcode field table; start from an all-zero bundle so nothing is ever X
  always_comb begin
    c     = '0;
    legal = 1'b1;
    casez (opc_i)
      OPC_HALT: c.halt = 1'b1;
      OPC_NOP:  c = '0;
`ifdef DECODE_EXC_EN
      OPC_SIIC: c.exc = 1'b1;
      OPC_RTI:  c.rti = 1'b1;
`else
      OPC_SIIC: legal = 1'b0;
      OPC_RTI:  legal = 1'b0;
`endif
      OPC_J:    begin c.jump = 1'b1; c.imm_sel = IMM_D11; end
      OPC_JR:   begin c.jump = 1'b1; c.jump_reg = 1'b1; c.imm_sel = IMM_S8; c.rs_rd = 1'b1; end
      OPC_JAL:  begin
        c.jump = 1'b1; c.link = 1'b1; c.imm_sel = IMM_D11;
        c.reg_wrt = 1'b1; c.reg_dst = DST_R7; c.wb_sel = WB_LINK;
      end
      OPC_JALR: begin
        c.jump = 1'b1; c.jump_reg = 1'b1; c.link = 1'b1; c.imm_sel = IMM_S8; c.rs_rd = 1'b1;
        c.reg_wrt = 1'b1; c.reg_dst = DST_R7; c.wb_sel = WB_LINK;
      end
      5'b010??: begin  // ADDI/SUBI sign-extend, XORI/ANDNI zero-extend
        c.alu_op = opc_i; c.reg_wrt = 1'b1; c.reg_dst = DST_RT; c.alu_src = 1'b1; c.rs_rd = 1'b1;
        c.imm_sel = opc_i[1] ? IMM_Z5 : IMM_S5;
      end
      5'b011??: begin  // BEQZ/BNEZ/BLTZ/BGEZ, condition in opcode low bits
        c.alu_op = opc_i; c.branch = 1'b1; c.br_cond = opc_i[1:0]; c.imm_sel = IMM_S8; c.rs_rd = 1'b1;
      end
      OPC_ST:   begin
        c.alu_op = opc_i; c.mem_wr = 1'b1; c.alu_src = 1'b1; c.imm_sel = IMM_S5; c.rs_rd = 1'b1;
      end
      OPC_LD:   begin
        c.alu_op = opc_i; c.mem_rd = 1'b1; c.reg_wrt = 1'b1; c.reg_dst = DST_RT; c.wb_sel = WB_MEM;
        c.alu_src = 1'b1; c.imm_sel = IMM_S5; c.rs_rd = 1'b1;
      end
      OPC_SLBI: begin
        c.alu_op = opc_i; c.reg_wrt = 1'b1; c.reg_dst = DST_RS; c.alu_src = 1'b1;
        c.imm_sel = IMM_Z8; c.rs_rd = 1'b1;
      end
      OPC_STU:  begin  // store, then write the updated address back to Rs
        c.alu_op = opc_i; c.mem_wr = 1'b1; c.reg_wrt = 1'b1; c.reg_dst = DST_RS;
        c.alu_src = 1'b1; c.imm_sel = IMM_S5; c.rs_rd = 1'b1;
      end
      5'b101??: begin  // ROLI/SLLI/RORI/SRLI
        c.alu_op = opc_i; c.reg_wrt = 1'b1; c.reg_dst = DST_RT; c.alu_src = 1'b1;
        c.imm_sel = IMM_Z5; c.rs_rd = 1'b1;
      end
      OPC_LBI:  begin
        c.alu_op = opc_i; c.reg_wrt = 1'b1; c.reg_dst = DST_RS; c.alu_src = 1'b1; c.imm_sel = IMM_S8;
      end
      OPC_BTR:  begin c.alu_op = opc_i; c.reg_wrt = 1'b1; c.reg_dst = DST_RD; c.rs_rd = 1'b1; end
      5'b1101?: begin  // R-format shift/arith, operation refined by funct bits
        c.alu_op = opc_i; c.reg_wrt = 1'b1; c.reg_dst = DST_RD; c.rs_rd = 1'b1; c.funct_en = 1'b1;
      end
      5'b111??: begin  // SEQ/SLT/SLE/SCO
        c.alu_op = opc_i; c.reg_wrt = 1'b1; c.reg_dst = DST_RD; c.rs_rd = 1'b1;
      end
      default:  legal = 1'b0;
    endcase
  end

  assign legal_o = legal;
  assign ctrl_o  = legal ? c : '0;

endmodule

// File: rtl/decode_stage_ctrl.sv
// Registered WISC decode stage: ID/EX register with stall/flush bubbles, halt drain FSM,
// sticky illegal-opcode capture and accepted-instruction counter.
// Build option: DECODE_EXC_EN (SIIC/RTI decoded as legal exception ops).
module decode_stage_ctrl
  import decode_pkg::*;
#(
  parameter int INSTR_W   = 16,
  parameter int OPC_W     = 5,
  parameter int CTRL_W    = 27,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid_i,
  input  logic [INSTR_W-1:0] if_instr_i,
  input  logic               id_stall_i,
  input  logic               id_flush_i,
  input  logic               ext_halt_i,
  output logic               id_ready_o,
  output logic               ex_valid_o,
  output logic [CTRL_W-1:0]  ex_ctrl_o,
  output logic [INSTR_W-1:0] ex_instr_o,
  output logic               halt_o,
  output logic               err_o,
  output logic [OPC_W-1:0]   err_opc_o,
  output logic [CNT_W-1:0]   dec_cnt_o
);

  localparam int DW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;

  logic [OPC_W-1:0]   opc;
  logic               rom_legal;
  logic [CTRL_W-1:0]  rom_ctrl;
  logic               accept;
  logic               halt_op;

  state_t             state_q, state_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic               pend_ext_q, pend_ext_d;  // pending halt came from ext_halt: not flushable

  logic               ex_valid_q;
  logic [CTRL_W-1:0]  ex_ctrl_q;
  logic [INSTR_W-1:0] ex_instr_q;
  logic               err_q;
  logic [OPC_W-1:0]   err_opc_q;
  logic [CNT_W-1:0]   cnt_q;

  assign opc = if_instr_i[INSTR_W-1 -: OPC_W];

  opc_ctrl_rom #(.OPC_W(OPC_W), .CTRL_W(CTRL_W)) u_rom (
    .opc_i   (opc),
    .legal_o (rom_legal),
    .ctrl_o  (rom_ctrl)
  );

  // Flush beats stall beats valid; nothing enters once a halt is pending
  assign accept  = if_valid_i & ~id_stall_i & ~id_flush_i & (state_q == ST_RUN);
  assign halt_op = accept & rom_ctrl[F_HALT];

  // Halt drain: count down DRAIN_CYC cycles, then park in HALTED until reset
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    pend_ext_d = pend_ext_q;
    unique case (state_q)
      ST_RUN: begin
        if (halt_op | ext_halt_i) begin
          state_d    = ST_HALT_PEND;
          drain_d    = DW'(DRAIN_CYC);
          pend_ext_d = ext_halt_i;
        end
      end
      ST_HALT_PEND: begin
        // an ext_halt arriving during an opcode-caused drain also makes it unflushable
        pend_ext_d = pend_ext_q | ext_halt_i;
        if (id_flush_i & ~pend_ext_d) begin
          state_d    = ST_RUN;   // halt was on a wrong path
          pend_ext_d = 1'b0;
        end else if (drain_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      drain_q    <= '0;
      pend_ext_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      pend_ext_q <= pend_ext_d;
    end
  end

  // ID/EX register: accepted instr moves on, otherwise a zero bundle bubble (instr holds)
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_instr_q <= '0;
    end else begin
      ex_valid_q <= accept;
      ex_ctrl_q  <= accept ? rom_ctrl : '0;
      if (accept) ex_instr_q <= if_instr_i;
    end
  end

  // Sticky first-illegal-opcode capture and wrapping accept counter
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_opc_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (accept) cnt_q <= cnt_q + CNT_W'(1);
      if (accept & ~rom_legal) begin
        err_q <= 1'b1;
        if (!err_q) err_opc_q <= opc;
      end
    end
  end

  assign id_ready_o = accept;
  assign ex_valid_o = ex_valid_q;
  assign ex_ctrl_o  = ex_ctrl_q;
  assign ex_instr_o = ex_instr_q;
  assign halt_o     = (state_q == ST_HALTED);
  assign err_o      = err_q;
  assign err_opc_o  = err_opc_q;
  assign dec_cnt_o  = cnt_q;

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Directed bench for decode_stage_ctrl (DRAIN_CYC=3, CNT_W=2 so the counter wraps quickly).
// Expected control bundles are hand-computed hex constants of the decode_pkg layout.
module tb_decode_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst, if_valid, id_stall, id_flush, ext_halt;
  logic [15:0] if_instr;
  logic        id_ready, ex_valid, halt, err;
  logic [26:0] ex_ctrl;
  logic [15:0] ex_instr;
  logic [4:0]  err_opc;
  logic [1:0]  dec_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage_ctrl #(
    .INSTR_W(16), .OPC_W(5), .CTRL_W(27), .DRAIN_CYC(3), .CNT_W(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid_i (if_valid),
    .if_instr_i (if_instr),
    .id_stall_i (id_stall),
    .id_flush_i (id_flush),
    .ext_halt_i (ext_halt),
    .id_ready_o (id_ready),
    .ex_valid_o (ex_valid),
    .ex_ctrl_o  (ex_ctrl),
    .ex_instr_o (ex_instr),
    .halt_o     (halt),
    .err_o      (err),
    .err_opc_o  (err_opc),
    .dec_cnt_o  (dec_cnt)
  );

  typedef struct packed {
    logic        vld;
    logic        stall;
    logic        flush;
    logic [15:0] instr;
    logic        rdy;
    logic        ev;
    logic [26:0] ctrl;
    logic [15:0] ei;
    logic [1:0]  cnt;
    logic        err;
    logic [4:0]  eopc;
  } vec_t;

  localparam int NV = 15;
  vec_t tv [NV];

  localparam logic [26:0] C_ADDI = 27'h4000368;
  localparam logic [26:0] C_LD   = 27'h4005371;
  localparam logic [26:0] C_ADD  = 27'h600003B;
  localparam logic [26:0] C_BNEZ = 27'h403060D;
  localparam logic [26:0] C_JAL  = 27'h0288AE0;
  localparam logic [26:0] C_LBI  = 27'h00007B8;
  localparam logic [26:0] C_ST   = 27'h4002310;
  localparam logic [26:0] C_XORI = 27'h400056A;
  localparam logic [26:0] C_HALT = 27'h0400000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic f, input logic e,
                       input logic [15:0] ins);
    if_valid = v; id_stall = s; id_flush = f; ext_halt = e; if_instr = ins;
  endtask

  initial begin
    tv[0]  = '{1'b1, 1'b0, 1'b0, 16'h4105, 1'b1, 1'b1, C_ADDI, 16'h4105, 2'd1, 1'b0, 5'd0};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 16'h8A21, 1'b0, 1'b0, 27'h0,  16'h4105, 2'd1, 1'b0, 5'd0};
    tv[2]  = '{1'b1, 1'b1, 1'b0, 16'h8A21, 1'b0, 1'b0, 27'h0,  16'h4105, 2'd1, 1'b0, 5'd0};
    tv[3]  = '{1'b1, 1'b0, 1'b0, 16'h8A21, 1'b1, 1'b1, C_LD,   16'h8A21, 2'd2, 1'b0, 5'd0};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 16'hD8E0, 1'b0, 1'b0, 27'h0,  16'h8A21, 2'd2, 1'b0, 5'd0};
    tv[5]  = '{1'b1, 1'b1, 1'b1, 16'hD8E0, 1'b0, 1'b0, 27'h0,  16'h8A21, 2'd2, 1'b0, 5'd0};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 16'hD8E0, 1'b1, 1'b1, C_ADD,  16'hD8E0, 2'd3, 1'b0, 5'd0};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 16'h6904, 1'b1, 1'b1, C_BNEZ, 16'h6904, 2'd0, 1'b0, 5'd0};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 16'h3000, 1'b1, 1'b1, C_JAL,  16'h3000, 2'd1, 1'b0, 5'd0};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 16'hC355, 1'b1, 1'b1, C_LBI,  16'hC355, 2'd2, 1'b0, 5'd0};
    tv[10] = '{1'b1, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1, C_ST,   16'h8000, 2'd3, 1'b0, 5'd0};
    tv[11] = '{1'b1, 1'b0, 1'b0, 16'h5000, 1'b1, 1'b1, C_XORI, 16'h5000, 2'd0, 1'b0, 5'd0};
    tv[12] = '{1'b1, 1'b0, 1'b0, 16'h0800, 1'b1, 1'b1, 27'h0,  16'h0800, 2'd1, 1'b0, 5'd0};
`ifdef DECODE_EXC_EN
    tv[13] = '{1'b1, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b1, 27'h0800000, 16'h1000, 2'd2, 1'b0, 5'd0};
    tv[14] = '{1'b1, 1'b0, 1'b0, 16'h1800, 1'b1, 1'b1, 27'h1000000, 16'h1800, 2'd3, 1'b0, 5'd0};
`else
    tv[13] = '{1'b1, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b1, 27'h0, 16'h1000, 2'd2, 1'b1, 5'h02};
    tv[14] = '{1'b1, 1'b0, 1'b0, 16'h1800, 1'b1, 1'b1, 27'h0, 16'h1800, 2'd3, 1'b1, 5'h02};
`endif

    // reset state
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (2) @(negedge clk);
    chk("rst ex_valid", 32'(ex_valid), 32'd0);
    chk("rst ex_ctrl",  32'(ex_ctrl),  32'd0);
    chk("rst ex_instr", 32'(ex_instr), 32'd0);
    chk("rst halt",     32'(halt),     32'd0);
    chk("rst err",      32'(err),      32'd0);
    chk("rst err_opc",  32'(err_opc),  32'd0);
    chk("rst dec_cnt",  32'(dec_cnt),  32'd0);
    rst = 1'b0;

    // table: decode, stall, flush, bubbles, counter wrap, illegal opcodes
    for (int i = 0; i < NV; i++) begin
      drive(tv[i].vld, tv[i].stall, tv[i].flush, 1'b0, tv[i].instr);
      #1 chk($sformatf("v%0d id_ready", i), 32'(id_ready), 32'(tv[i].rdy));
      @(negedge clk);
      chk($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'(tv[i].ev));
      chk($sformatf("v%0d ex_ctrl", i),  32'(ex_ctrl),  32'(tv[i].ctrl));
      chk($sformatf("v%0d ex_instr", i), 32'(ex_instr), 32'(tv[i].ei));
      chk($sformatf("v%0d dec_cnt", i),  32'(dec_cnt),  32'(tv[i].cnt));
      chk($sformatf("v%0d err", i),      32'(err),      32'(tv[i].err));
      chk($sformatf("v%0d err_opc", i),  32'(err_opc),  32'(tv[i].eopc));
    end

    // HALT accepted, flushed next cycle: wrong-path halt cancelled
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1 chk("hf halt ready", 32'(id_ready), 32'd1);
    @(negedge clk);
    chk("hf halt ctrl", 32'(ex_ctrl), 32'(C_HALT));
    chk("hf halt cnt",  32'(dec_cnt), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'hD8E0);
    #1 chk("hf add ready", 32'(id_ready), 32'd1);
    @(negedge clk);
    chk("hf add ctrl", 32'(ex_ctrl), 32'(C_ADD));
    chk("hf add cnt",  32'(dec_cnt), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (5) @(negedge clk);
    chk("hf halt low", 32'(halt), 32'd0);

    // HALT opcode together with flush: not accepted, no halt
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    #1 chk("hff ready", 32'(id_ready), 32'd0);
    @(negedge clk);
    chk("hff ex_valid", 32'(ex_valid), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (5) @(negedge clk);
    chk("hff halt low", 32'(halt), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'hD8E0);
    #1 chk("hff run ready", 32'(id_ready), 32'd1);
    @(negedge clk);
    chk("hff cnt", 32'(dec_cnt), 32'd2);

    // ext_halt pend ignores flush; reset mid-drain returns to RUN
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'hD8E0);
    #1 chk("ext pend ready", 32'(id_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ext rst halt", 32'(halt),     32'd0);
    chk("ext rst cnt",  32'(dec_cnt),  32'd0);
    chk("ext rst err",  32'(err),      32'd0);
    chk("ext rst vld",  32'(ex_valid), 32'd0);
    #1 chk("ext rst ready", 32'(id_ready), 32'd1);
    @(negedge clk);
    chk("ext add cnt", 32'(dec_cnt), 32'd1);

    // HALT drain: halt rises exactly 4 edges after acceptance, then input ignored
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1 chk("hd ready", 32'(id_ready), 32'd1);
    @(negedge clk);
    chk("hd ex_valid", 32'(ex_valid), 32'd1);
    chk("hd e0 halt",  32'(halt),     32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'hD8E0);
    for (int k = 1; k <= 3; k++) begin
      #1 chk($sformatf("hd e%0d ready", k), 32'(id_ready), 32'd0);
      @(negedge clk);
      chk($sformatf("hd e%0d halt", k), 32'(halt), 32'd0);
    end
    @(negedge clk);
    chk("hd e4 halt", 32'(halt), 32'd1);
    repeat (3) @(negedge clk);
    chk("hd halted ready", 32'(id_ready), 32'd0);
    chk("hd halted valid", 32'(ex_valid), 32'd0);
    chk("hd halted cnt",   32'(dec_cnt),  32'd2);
    chk("hd halted halt",  32'(halt),     32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
